// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg: shared md_op encodings and latency constants for e_mdu | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
  localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;
  localparam logic [CNT_W-1:0] CNT_ONE     = 4'd1;

  // mult/multu/div/divu occupy the lower half of the encoding space
  function automatic logic is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu: E-stage multiply/divide unit with architectural HI/LO | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module e_mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic        busy,
  output logic [31:0] E_MDresult,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [31:0]      rs_q, rs_d;
  logic [31:0]      rt_q, rt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             accept;
  logic             done;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      dvd_mag, dvs_mag;
  logic [31:0]      quo_mag, rem_mag;
  logic [31:0]      quo_s, rem_s;
  logic [31:0]      quo_u, rem_u;
  logic             quo_neg;
  logic             dvs_zero;

  assign busy   = (cnt_q != '0);
  assign accept = start && !busy && is_arith(md_op);
  assign done   = (cnt_q == CNT_ONE);

  // Result datapath works only on captured operands, so forwarded inputs may
  // change freely while the operation is in flight.
  assign prod_s = $signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{rt_q[31]}}, rt_q});
  assign prod_u = {32'd0, rs_q} * {32'd0, rt_q};

  assign dvs_zero = (rt_q == 32'd0);
  assign dvd_mag  = abs32(rs_q);
  assign dvs_mag  = dvs_zero ? 32'd1 : abs32(rt_q);
  assign quo_mag  = dvd_mag / dvs_mag;
  assign rem_mag  = dvd_mag % dvs_mag;
  // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 with rem 0
  assign quo_neg  = rs_q[31] ^ rt_q[31];
  assign quo_s    = quo_neg  ? neg32(quo_mag) : quo_mag;
  assign rem_s    = rs_q[31] ? neg32(rem_mag) : rem_mag;

  assign quo_u = rs_q / (dvs_zero ? 32'd1 : rt_q);
  assign rem_u = rs_q % (dvs_zero ? 32'd1 : rt_q);

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    rs_d  = rs_q;
    rt_d  = rt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept) begin
      cnt_d = md_op[1] ? DIV_CYCLES : MULT_CYCLES;
      op_d  = md_op_e'(md_op);
      rs_d  = E_rs;
      rt_d  = E_rt;
    end else if (busy) begin
      cnt_d = cnt_q - CNT_ONE;
      if (done) begin
        case (op_q)
          MD_MULT:  {hi_d, lo_d} = prod_s;
          MD_MULTU: {hi_d, lo_d} = prod_u;
          MD_DIV: begin
            if (!dvs_zero) begin
              hi_d = rem_s;
              lo_d = quo_s;
            end
          end
          MD_DIVU: begin
            if (!dvs_zero) begin
              hi_d = rem_u;
              lo_d = quo_u;
            end
          end
          default: ;
        endcase
      end
    end else if (!start) begin
      if (md_op == MD_MTHI) begin
        hi_d = E_rs;
      end else if (md_op == MD_MTLO) begin
        lo_d = E_rs;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= MD_MULT;
      rs_q  <= '0;
      rt_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      rs_q  <= rs_d;
      rt_q  <= rt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  always_comb begin
    E_MDresult = '0;
    if (md_op == MD_MFHI) begin
      E_MDresult = hi_q;
    end else if (md_op == MD_MFLO) begin
      E_MDresult = lo_q;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu: scoreboard bench for e_mdu against a plain-arithmetic HI/LO model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_e_mdu;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd7;
  logic [31:0] E_rs  = 32'd0;
  logic [31:0] E_rt  = 32'd0;
  logic        busy;
  logic [31:0] E_MDresult;
  logic [31:0] HI;
  logic [31:0] LO;

  e_mdu dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .md_op      (md_op),
    .E_rs       (E_rs),
    .E_rt       (E_rt),
    .busy       (busy),
    .E_MDresult (E_MDresult),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from ordinary 64-bit integer maths
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] h,
                                 input logic [31:0] l);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    e.hi  = h;
    e.lo  = l;
    e.lat = (op >= 3'd2) ? 10 : 5;
    case (op)
      3'd0: begin
        p = sa * sb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd2: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      default: begin
        if (b != 32'd0) begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every busy falling edge presents one completed result
  initial begin : mon
    logic prev;
    int   bc;
    exp_t e;
    prev = 1'b0;
    bc   = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b0;
        bc   = 0;
      end else begin
        if (busy) begin
          bc++;
        end else if (prev) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: HI=%h LO=%h, expected no completion", HI, LO);
          end else begin
            e = sbq.pop_front();
            check("res_hi", HI, e.hi);
            check("res_lo", LO, e.lo);
            check("busy_len", 32'(bc), 32'(e.lat));
          end
          bc = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 50) begin
      tick();
      g++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy=%b, expected 0", busy);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] oh, ol;
    wait_idle();
    oh = mhi;
    ol = mlo;
    start = 1'b1;
    md_op = op;
    E_rs  = a;
    E_rt  = b;
    e = model(op, a, b, mhi, mlo);
    mhi = e.hi;
    mlo = e.lo;
    sbq.push_back(e);
    tick();
    start = 1'b0;
    md_op = 3'd7;
    E_rs  = $urandom;
    E_rt  = $urandom;
    check("busy_rise", 32'(busy), 32'd1);
    check("hold_hi", HI, oh);
    check("hold_lo", LO, ol);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    md_op = op;
    E_rs  = v;
    if (!busy) begin
      if (op == 3'd4) mhi = v;
      else            mlo = v;
    end
    tick();
    md_op = 3'd7;
  endtask

  task automatic mf_check();
    wait_idle();
    md_op = 3'd6;
    #1;
    check("mfhi", E_MDresult, mhi);
    md_op = 3'd7;
    #1;
    check("mflo", E_MDresult, mlo);
    md_op = 3'd0;
    #1;
    check("mdres_zero", E_MDresult, 32'd0);
    md_op = 3'd7;
  endtask

  task automatic busy_start_pulse();
    start = 1'b1;
    md_op = 3'($urandom_range(0, 3));
    E_rs  = $urandom;
    E_rt  = $urandom;
    tick();
    start = 1'b0;
    md_op = 3'd7;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    summary();
    $fatal(1);
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_mdres", E_MDresult, 32'd0);
    reset = 1'b1;

    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd7, 32'd0);
    mf_check();

    issue(3'd0, 32'd5, 32'd6);
    mt(3'd5, 32'h1234);
    wait_idle();
    mt(3'd5, 32'h1234);
    mf_check();

    issue(3'd2, 32'd100, 32'd7);
    busy_start_pulse();
    busy_start_pulse();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    mf_check();

    issue(3'd0, 32'd123, 32'd456);
    tick();
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    sbq.delete();
    mhi = 32'd0;
    mlo = 32'd0;
    tick();
    reset = 1'b1;
    issue(3'd0, 32'd3, 32'd4);

    issue(3'd3, 32'd9, 32'd2);
    issue(3'd1, 32'd3, 32'd3);
    mf_check();

    repeat (60) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: issue(3'($urandom_range(0, 3)), rnd32(), rnd32());
        6, 7:             mt(3'($urandom_range(4, 5)), $urandom);
        8:                mf_check();
        default: begin
          if (busy) busy_start_pulse();
          else      tick();
        end
      endcase
    end

    wait_idle();
    repeat (3) tick();
    mf_check();
    check("sb_empty", 32'(sbq.size()), 32'd0);
    summary();
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL provide: start  input  1  E-stage carries a mult/multu/div/divu instruction this cycle.
REQ-004 SHALL provide: md_op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
REQ-005 SHALL provide: E_rs  input  32  forwarded rs operand.
REQ-006 SHALL provide: E_rt  input  32  forwarded rt operand.
REQ-007 SHALL provide: busy  output  1  multi-cycle operation in progress.
REQ-008 SHALL provide: E_MDresult  output  32  HI (md_op 6) or LO (md_op 7), else 0; feeds the E/M ALU-result mux.
REQ-009 SHALL provide: HI, LO  output  32 each  architectural HI/LO registers, for debug.

Function
REQ-010 SHALL capture E_rs, E_rt and md_op on the rising edge where start=1 and busy=0.
REQ-011 SHALL assert busy from the cycle after that start edge for exactly 5 cycles (mult/multu) or 10 cycles (div/divu), via a down-counter.
REQ-012 SHALL update HI/LO on the same edge where busy falls; HI/LO SHALL hold their old values while busy=1.
REQ-013 mult SHALL form the signed 64-bit product; multu the unsigned one; {HI,LO} = product.
REQ-014 div/divu SHALL give LO = quotient and HI = remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-015 Divisor 0 SHALL leave HI and LO unchanged, with normal busy timing.
REQ-016 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-017 mthi/mtlo (md_op 4/5, start=0) SHALL write E_rs into HI/LO on the next edge when busy=0; they SHALL be ignored while busy=1.
REQ-018 start while busy=1 SHALL be ignored; the counter and captured operands SHALL be unaffected.
REQ-019 E_MDresult SHALL be combinational from the current HI/LO registers, with no bypass of a pending result.
REQ-020 The hazard unit stalls D on any HI/LO-class instruction when (start | busy); e_mdu SHALL NOT generate stall itself.
REQ-021 The final busy edge and a new start on the following cycle SHALL be accepted back-to-back, with no dead cycle.

Reset
REQ-022 reset=0 SHALL, asynchronously, clear HI, LO, the counter, captured operands and busy to 0.
REQ-023 reset asserted mid-operation SHALL abort it; after release, busy=0 and HI/LO=0.
REQ-024 First start is honoured on the first rising edge after reset deasserts.

Structure
REQ-025 The md_op encodings and the constants MULT_CYCLES=5 and DIV_CYCLES=10 SHALL live in the shared package mdu_pkg.
REQ-026 Single module, no sub-modules; arithmetic uses behavioural operators, result computed from captured operands at completion.

Verification
REQ-027 mult with E_rs=0xFFFFFFFF, E_rt=2 -> busy high for cycles 1..5; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-028 multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 div with E_rs=-7, E_rt=2 -> busy high 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/0 -> HI/LO unchanged.
REQ-030 mtlo 0x1234 during busy -> ignored; mtlo after busy falls -> LO=0x1234, and mflo E_MDresult=0x1234 the next cycle.
REQ-031 start mult, then reset=0 at cycle 3 -> busy=0 immediately and HI=LO=0; a new mult 3*4 after release -> LO=12 after 5 cycles.
REQ-032 Back-to-back: divu 9/2 then start multu 3*3 on the cycle busy falls -> HI=1, LO=4, then HI=0, LO=9 five cycles later.
